serial_subtractor_18: RTL and testbench
=======================================

// Module: serial_subtractor_18
// PURPOSE
//  Bit-serial unsigned subtractor: computes diff = a - b (mod 2^WIDTH) and the
//  final borrow, one bit per clock, LSB first, using a single full-subtractor cell.
//  It is the inverse-operation companion to the parallel ripple-carry adder in the
//  arithmetic library. It serves area-constrained datapaths that accept
//  WIDTH-cycle latency, and uses a start/busy/done handshake.
// PARAMETERS
//  WIDTH  18  operand/result width in bits (>= 2)
// PORTS
//  clk     in   1      rising-edge clock; the only clock
//  rst     in   1      synchronous, active-high reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  minuend, captured on the accepting edge
//  b       in   WIDTH  subtrahend, captured on the accepting edge
//  busy    out  1      high whenever state != IDLE
//  done    out  1      one-cycle pulse; diff/borrow are valid while it is high
//  diff    out  WIDTH  result register; holds until the next result is written
//  borrow  out  1      1 iff a < b (unsigned); holds with diff
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, diff=0, borrow=0; internal regs cleared.
//  FSM states are IDLE, SHIFT and DONE.
//  IDLE -> SHIFT on the edge E0 where start=1:
//   - latch a, b into shift regs
//   - bin=0, cnt=0
//   - result shift reg cleared
//  SHIFT runs WIDTH cycles, one bit per edge (edges E1..EW):
//   - x = opa[0], y = opb[0]
//   - d    = x ^ y ^ bin
//   - bout = (~x & y) | (~(x ^ y) & bin)
//   - result shift reg shifts right, with d entering at MSB
//   - opa and opb shift right
//   - bin <= bout; cnt++
//  At edge EW (cnt == WIDTH-1): -> DONE
//   - diff <= final shifted result
//   - borrow <= final bout
//  DONE -> IDLE at the next edge, unconditionally.
//  Timing:
//   - done=1 for exactly the cycle between EW and EW+1
//   - busy=1 from after E0 through that DONE cycle
//   - a start in the DONE cycle is ignored
//   - a new start is accepted in the first IDLE cycle (back-to-back period
//     is WIDTH+2 cycles)
//  start while busy: ignored. It causes no restart, and a/b are not resampled.
//  a and b may change freely after E0 without affecting the result.
//  diff/borrow change only at the edge entering DONE or on rst. They keep the
//   previous result during a new operation.
//  cnt is sized to hold WIDTH-1; it never wraps.
//  rst mid-operation (any state): immediately returns to IDLE with all outputs 0.
//   The aborted result is never presented and done does not pulse.
//  rst and start both high on the same edge: rst wins and the start is dropped.
// TESTING (WIDTH=18)
//  1. a=5, b=3 -> done 18 edges after accept; diff=2, borrow=0; busy high 19 cycles.
//  2. a=3, b=5 -> diff=0x3FFFE, borrow=1. Then a=0, b=0x3FFFF -> diff=1, borrow=1.
//  3. a=0x3FFFF, b=0 -> diff=0x3FFFF, borrow=0. Then a=b=0x2AAAA -> diff=0, borrow=0.
//  4. Pulse start with a=9, b=4 at cycle 5 of the operation:
//     -> ignored; the first result is unchanged; exactly one done pulse.
//  5. Hold start high continuously -> back-to-back ops, one done every 20 cycles,
//     with diff stable between pulses.
//  6. Assert rst at SHIFT cycle 10 -> next cycle busy=0, diff=0, borrow=0, no done.
//     Then start a=100, b=1 -> diff=99.

Source files
------------

// File: rtl/serial_subtractor_18_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_18_if
//   Handshake and operand/result bundle for the bit-serial subtractor.
//   master : the requester (drives start/a/b, observes busy/done/diff/borrow)
//   slave  : the subtractor itself
//   Signals:
//     start  request, sampled by the slave only while it is idle
//     a, b   minuend / subtrahend, captured on the accepting edge
//     busy   slave is not idle
//     done   one-cycle pulse, diff/borrow valid while high
//     diff   result register (a - b mod 2^WIDTH)
//     borrow 1 iff a < b (unsigned)
// ---------------------------------------------------------------------------
interface serial_subtractor_18_if #(
  parameter int WIDTH = 18
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor_18.sv
// ---------------------------------------------------------------------------
// serial_subtractor_18
//   Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH) plus the final
//   borrow, one bit per clock, LSB first, through a single full-subtractor
//   cell. An accepted request takes WIDTH shift cycles followed by a single
//   DONE cycle in which done pulses.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  serial_subtractor_18_if.slave (start/a/b in, busy/done/diff/borrow out)
// ---------------------------------------------------------------------------
module serial_subtractor_18 #(
  parameter int WIDTH = 18
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_subtractor_18_if.slave       bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Full-subtractor cell on the current LSBs.
  logic               x, y, d_bit, bout;
  logic [WIDTH-1:0]   res_shift;
  logic               last_bit;

  assign x         = opa_q[0];
  assign y         = opb_q[0];
  assign d_bit     = x ^ y ^ bin_q;
  assign bout      = (~x & y) | (~(x ^ y) & bin_q);
  assign res_shift = {d_bit, res_q[WIDTH-1:1]};
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

  // ---------------- Datapath next-state ----------------
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d = bus.a;
          opb_d = bus.b;
          res_d = '0;
          bin_d = 1'b0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        res_d = res_shift;
        bin_d = bout;
        if (last_bit) begin
          // Result registers update only here, so they hold the previous
          // answer throughout the next operation.
          diff_d   = res_shift;
          borrow_d = bout;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // ---------------- Datapath registers ----------------
  // NOTE: the operand/result shift registers are plain flops, not a memory,
  // and are cleared on reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor_18.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_18
//   Self-checking bench for serial_subtractor_18 (WIDTH = 18). Expected
//   results come from plain modular arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_18;

  localparam int WIDTH = 18;
  localparam int MOD   = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Last result the model says the DUT should be holding.
  logic [WIDTH-1:0] last_diff   = '0;
  logic             last_borrow = 1'b0;

  serial_subtractor_18_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor_18 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_diff(input int unsigned av, input int unsigned bv);
    return WIDTH'((av + MOD - bv) % MOD);
  endfunction

  function automatic logic model_borrow(input int unsigned av, input int unsigned bv);
    return av < bv;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 4 * WIDTH) begin
      tick();
      n++;
    end
    check("wait_idle", bus.busy, 1'b0);
  endtask

  // One full operation. mid_start > 0 pulses start (a=9, b=4) in that cycle
  // of the operation; it must be ignored.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input int mid_start);
    int lat;
    int busy_cycles;
    logic [WIDTH-1:0] ed;
    logic             eb;
    ed = model_diff(av, bv);
    eb = model_borrow(av, bv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    tick();
    // Operands are free to change once accepted.
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    check("accept_busy", bus.busy, 1'b1);
    busy_cycles = 1;
    lat = 0;
    while (!bus.done && lat < 3 * WIDTH) begin
      bus.start = (mid_start > 0 && lat == mid_start);
      if (bus.start) begin
        bus.a = WIDTH'(9);
        bus.b = WIDTH'(4);
      end
      tick();
      lat++;
      if (bus.busy) busy_cycles++;
      if (lat == WIDTH / 2) begin
        check("hold_diff", bus.diff, last_diff);
        check("hold_borrow", bus.borrow, last_borrow);
      end
    end
    bus.start = 1'b0;
    check("latency", lat, WIDTH);
    check("diff", bus.diff, ed);
    check("borrow", bus.borrow, eb);
    check("busy_cycles", busy_cycles, WIDTH + 1);
    last_diff   = ed;
    last_borrow = eb;
    tick();
    check("done_one_cycle", bus.done, 1'b0);
    check("idle_after_done", bus.busy, 1'b0);
  endtask

  // Count done pulses over a window; expect none.
  task automatic expect_quiet(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  task automatic back_to_back(input int n_ops);
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] cur_a, cur_b, pa, pb;
    logic prev_busy;
    int dones = 0;
    int cyc = 0;
    int last_done_cyc = -1;
    cur_a = WIDTH'($urandom);
    cur_b = WIDTH'($urandom);
    bus.a = cur_a;
    bus.b = cur_b;
    bus.start = 1'b1;
    prev_busy = 1'b0;
    while (dones < n_ops && cyc < (n_ops + 2) * (WIDTH + 2)) begin
      tick();
      cyc++;
      if (bus.busy && !prev_busy) begin
        qa.push_back(cur_a);
        qb.push_back(cur_b);
        cur_a = WIDTH'($urandom);
        cur_b = WIDTH'($urandom);
        bus.a = cur_a;
        bus.b = cur_b;
      end
      if (bus.done) begin
        if (qa.size() > 0) begin
          pa = qa.pop_front();
          pb = qb.pop_front();
          last_diff   = model_diff(pa, pb);
          last_borrow = model_borrow(pa, pb);
        end
        check("b2b_diff", bus.diff, last_diff);
        check("b2b_borrow", bus.borrow, last_borrow);
        if (last_done_cyc >= 0) check("b2b_period", cyc - last_done_cyc, WIDTH + 2);
        last_done_cyc = cyc;
        dones++;
      end else begin
        check("b2b_hold", bus.diff, last_diff);
      end
      prev_busy = bus.busy;
    end
    check("b2b_count", dones, n_ops);
    bus.start = 1'b0;
    wait_idle();
    // An accept may have happened just before start dropped; drain it.
    if (qa.size() > 0) begin
      last_diff   = model_diff(qa[0], qb[0]);
      last_borrow = model_borrow(qa[0], qb[0]);
      check("b2b_drain_diff", bus.diff, last_diff);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    tick();
    tick();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_diff", bus.diff, '0);
    check("rst_borrow", bus.borrow, 1'b0);
    rst = 1'b0;
    tick();

    // Directed corner cases.
    run_op(18'd5, 18'd3, 0);
    run_op(18'd3, 18'd5, 0);
    run_op(18'd0, 18'h3FFFF, 0);
    run_op(18'h3FFFF, 18'd0, 0);
    run_op(18'h2AAAA, 18'h2AAAA, 0);

    // Start pulsed mid-operation is ignored; no second result follows.
    run_op(18'd1000, 18'd77, 5);
    expect_quiet("ignored_start_no_done", 2 * WIDTH);
    check("ignored_start_idle", bus.busy, 1'b0);
    check("ignored_start_diff", bus.diff, last_diff);

    // Randomized operations, some with equal operands.
    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom);
      rb = (i % 5 == 0) ? ra : WIDTH'($urandom);
      run_op(ra, rb, 0);
    end

    // Start held high continuously.
    back_to_back(5);

    // Reset in the middle of SHIFT aborts without a done pulse.
    bus.start = 1'b1;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_diff", bus.diff, '0);
    check("abort_borrow", bus.borrow, 1'b0);
    last_diff   = '0;
    last_borrow = 1'b0;
    expect_quiet("abort_no_done", WIDTH + 4);
    run_op(18'd100, 18'd1, 0);

    // Reset and start on the same edge: reset wins.
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy", bus.busy, 1'b0);
    check("rst_start_diff", bus.diff, '0);
    last_diff   = '0;
    last_borrow = 1'b0;
    expect_quiet("rst_start_no_done", WIDTH + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
